pipe_stage_reg: RTL and testbench

- Parametrised pipeline stage register; the generalised successor to the fixed IF/ID latch.
- Carries a DATA_W payload (default: 30-bit PC+4 concatenated with a 32-bit instruction) between any two pipeline stages.
- Uses a valid/ready handshake, a one-entry skid buffer so upstream ready is fully registered, synchronous flush that injects a bubble value, and a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_stage_reg.sv | 108 ++++++++++
 tb/tb_pipe_stage_reg.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register: valid/ready handshake with a one-entry
// skid buffer, synchronous flush to a bubble, and a saturating stall counter.
module pipe_stage_reg #(
  parameter int                 DATA_W     = 62,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0,
  parameter int                 CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Encoding is {skid_valid, main_valid}; 2'b10 never occurs.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                acc, drn;

  assign in_ready  = ~state_q[1];
  assign out_valid = state_q[0];
  assign out_data  = state_q[0] ? main_data_q : BUBBLE_VAL;
  assign stall_cnt = cnt_q;

  assign acc = in_valid & in_ready;
  assign drn = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      main_data_q <= BUBBLE_VAL;
      skid_data_q <= BUBBLE_VAL;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    case (state_q)
      EMPTY: begin
        if (acc) begin
          main_data_d = in_data;
          state_d     = FULL;
        end
      end
      FULL: begin
        if (acc && drn) begin
          main_data_d = in_data;
        end else if (drn) begin
          main_data_d = BUBBLE_VAL;
          state_d     = EMPTY;
        end else if (acc) begin
          skid_data_d = in_data;
          state_d     = SKID;
        end
      end
      SKID: begin
        if (drn) begin
          main_data_d = skid_data_q;
          skid_data_d = BUBBLE_VAL;
          state_d     = FULL;
        end
      end
      default: begin
        main_data_d = BUBBLE_VAL;
        skid_data_d = BUBBLE_VAL;
        state_d     = EMPTY;
      end
    endcase
    // A flush discards whatever was accepted this cycle as well as held beats.
    if (flush) begin
      main_data_d = BUBBLE_VAL;
      skid_data_d = BUBBLE_VAL;
      state_d     = EMPTY;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (instantiated with CNT_W=4).
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [61:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [61:0] out_data;
  logic        out_ready;
  logic        flush;
  logic        cnt_clr;
  logic [3:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(
    .DATA_W    (62),
    .BUBBLE_VAL(62'h0),
    .CNT_W     (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .flush    (flush),
    .cnt_clr  (cnt_clr),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; in_data = 62'h1234; out_ready = 1'b1;
    flush = 1'b0; cnt_clr = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== 62'h0) begin errors++; $display("[TB] FAIL rst_out_data got %h want 0", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_ready got %0b want 1", in_ready); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("[TB] FAIL rst_stall_cnt got %0d want 0", stall_cnt); end
    rst = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL pass_out_valid got %0b want 1", out_valid); end
    checks++; if (out_data !== 62'h1234) begin errors++; $display("[TB] FAIL pass_out_data got %h want 1234", out_data); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL pass_drain_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== 62'h0) begin errors++; $display("[TB] FAIL pass_drain_data got %h want 0", out_data); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 62'(i);
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 62'(i)) begin errors++; $display("[TB] FAIL stream_beat%0d got v=%0b d=%h want v=1 d=%h", i, out_valid, out_data, 62'(i)); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stream_in_ready%0d got %0b want 1", i, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_end_valid got %0b want 0", out_valid); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("[TB] FAIL stream_stall_cnt got %0d want 0", stall_cnt); end
  endtask

  task automatic test_skid();
    in_valid = 1'b1; in_data = 62'hAA; out_ready = 1'b0;
    tick();
    checks++; if (out_data !== 62'hAA) begin errors++; $display("[TB] FAIL skid_a_out got %h want aa", out_data); end
    in_data = 62'hBB;
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL skid_full_ready got %0b want 0", in_ready); end
    checks++; if (out_data !== 62'hAA || stall_cnt !== 4'd1) begin errors++; $display("[TB] FAIL skid_hold_a got d=%h cnt=%0d want d=aa cnt=1", out_data, stall_cnt); end
    in_data = 62'hCC;
    tick();
    checks++; if (in_ready !== 1'b0 || out_data !== 62'hAA || stall_cnt !== 4'd2) begin errors++; $display("[TB] FAIL skid_stall2 got r=%0b d=%h cnt=%0d want r=0 d=aa cnt=2", in_ready, out_data, stall_cnt); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 62'hBB || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL skid_out_b got v=%0b d=%h r=%0b want v=1 d=bb r=1", out_valid, out_data, in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 62'hCC) begin errors++; $display("[TB] FAIL skid_out_c got v=%0b d=%h want v=1 d=cc", out_valid, out_data); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || stall_cnt !== 4'd2) begin errors++; $display("[TB] FAIL skid_done got v=%0b cnt=%0d want v=0 cnt=2", out_valid, stall_cnt); end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("[TB] FAIL skid_clr got %0d want 0", stall_cnt); end
  endtask

  task automatic test_flush_skid();
    in_valid = 1'b1; in_data = 62'hD0; out_ready = 1'b0;
    tick();
    in_data = 62'hE0;
    tick();
    checks++; if (in_ready !== 1'b0 || stall_cnt !== 4'd1) begin errors++; $display("[TB] FAIL flush_setup got r=%0b cnt=%0d want r=0 cnt=1", in_ready, stall_cnt); end
    // The flush cycle itself is still a stalled cycle, so the counter reaches 2.
    flush = 1'b1; in_data = 62'hF0;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0 || out_data !== 62'h0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_bubble got v=%0b d=%h r=%0b want v=0 d=0 r=1", out_valid, out_data, in_ready); end
    checks++; if (stall_cnt !== 4'd2) begin errors++; $display("[TB] FAIL flush_cnt got %0d want 2", stall_cnt); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0 || out_data !== 62'h0) begin errors++; $display("[TB] FAIL flush_no_ghost%0d got v=%0b d=%h want v=0 d=0", i, out_valid, out_data); end
    end
    in_valid = 1'b1; in_data = 62'h66;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 62'h66 || stall_cnt !== 4'd2) begin errors++; $display("[TB] FAIL flush_next_beat got v=%0b d=%h cnt=%0d want v=1 d=66 cnt=2", out_valid, out_data, stall_cnt); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_next_drain got %0b want 0", out_valid); end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  task automatic test_saturation();
    logic [3:0] exp;
    in_valid = 1'b1; in_data = 62'h77; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("[TB] FAIL sat_start got %0d want 0", stall_cnt); end
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp = (i > 15) ? 4'd15 : 4'(i);
      checks++; if (stall_cnt !== exp) begin errors++; $display("[TB] FAIL sat_step%0d got %0d want %0d", i, stall_cnt, exp); end
    end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("[TB] FAIL sat_clr got %0d want 0", stall_cnt); end
    tick();
    checks++; if (stall_cnt !== 4'd1) begin errors++; $display("[TB] FAIL sat_after_clr got %0d want 1", stall_cnt); end
    checks++; if (out_data !== 62'h77) begin errors++; $display("[TB] FAIL sat_hold_data got %h want 77", out_data); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL sat_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; in_data = 62'h88; out_ready = 1'b0;
    tick();
    in_data = 62'h99;
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL areset_setup got r=%0b v=%0b want r=0 v=1", in_ready, out_valid); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL areset_immediate got v=%0b r=%0b want v=0 r=1", out_valid, in_ready); end
    checks++; if (out_data !== 62'h0 || stall_cnt !== 4'd0) begin errors++; $display("[TB] FAIL areset_values got d=%h cnt=%0d want d=0 cnt=0", out_data, stall_cnt); end
    tick();
    rst = 1'b1; out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 62'h0) begin errors++; $display("[TB] FAIL areset_no_retain got v=%0b d=%h want v=0 d=0", out_valid, out_data); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_skid();
    test_flush_skid();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
